ps2_keycode_rx: RTL and testbench

PS2_KEYCODE_RX -- requirements
Module: ps2_keycode_rx

---
 rtl/ps2_pkg.sv | 25 ++
 rtl/ps2_keycode_rx_if.sv | 23 ++
 rtl/ps2_sync_filter.sv | 63 ++++++
 rtl/ps2_keycode_rx.sv | 187 ++++++++++++++++++
 tb/tb_ps2_keycode_rx.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keycode receiver.
//   ps2_state_e     : frame receiver FSM states
//   PS2_PREFIX_EXT  : extended-key prefix byte (E0)
//   PS2_PREFIX_BRK  : break (key release) prefix byte (F0)
//   PS2_KEY_NONE    : keycode value meaning "no key held"
//   odd_parity_ok() : frame parity check over data + parity bit
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0]  PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0]  PS2_PREFIX_BRK = 8'hF0;
  localparam logic [15:0] PS2_KEY_NONE   = 16'h0000;

  // PS/2 uses odd parity: data bits plus parity bit hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_keycode_rx_if.sv
// Signal bundle between a PS/2 device side and the keycode receiver.
//   ps2_clk, ps2_data : raw PS/2 lines, asynchronous to the system clock
//   keycode           : held key {prefix, scan code}, 16'h0000 when none
//   key_valid         : one-cycle pulse when keycode changes
//   frame_err         : one-cycle pulse on parity/stop error or timeout
// master = device/stimulus side, slave = receiver.
interface ps2_keycode_rx_if;
  logic        ps2_clk;
  logic        ps2_data;
  logic [15:0] keycode;
  logic        key_valid;
  logic        frame_err;

  modport master (
    output ps2_clk, ps2_data,
    input  keycode, key_valid, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output keycode, key_valid, frame_err
  );
endinterface

// File: rtl/ps2_sync_filter.sv
// PS/2 line conditioning: 2-flop synchronizers on both lines, a glitch
// filter on the clock line and a falling-edge detector on the filtered clock.
//   clk, rst   : system clock, asynchronous active-high reset
//   ps2_clk    : raw PS/2 clock
//   ps2_data   : raw PS/2 data
//   data_s     : synchronized PS/2 data
//   fall_pulse : one-cycle pulse on each falling edge of the filtered clock
// FILTER_LEN must be at least 2.
module ps2_sync_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic data_s,
  output logic fall_pulse
);

  logic [1:0]            clk_sync_q;
  logic [1:0]            data_sync_q;
  logic [FILTER_LEN-1:0] hist_q, hist_d;
  logic                  filt_q, filt_d;
  logic                  fall_q, fall_d;

  // NOTE: every variable gets a default before any branch so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    hist_d = {hist_q[FILTER_LEN-2:0], clk_sync_q[1]};
    filt_d = filt_q;
    // The filtered level only moves once the last FILTER_LEN samples agree.
    if (&hist_q) begin
      filt_d = 1'b1;
    end else if (~|hist_q) begin
      filt_d = 1'b0;
    end
    fall_d = filt_q & ~filt_d;
  end

  // Everything resets to the idle-high bus level so that releasing reset
  // with the bus idle cannot look like a falling edge.
  // NOTE: sequential state uses non-blocking assignments so all flops see the
  // pre-edge values of each other, exactly like the hardware.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      hist_q      <= '1;
      filt_q      <= 1'b1;
      fall_q      <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
      hist_q      <= hist_d;
      filt_q      <= filt_d;
      fall_q      <= fall_d;
    end
  end

  assign data_s     = data_sync_q[1];
  assign fall_pulse = fall_q;

endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard receiver: deframes 11-bit PS/2 frames and tracks the key
// currently held, folding E0 (extended) and F0 (break) prefixes.
//   clk, rst : system clock, asynchronous active-high reset
//   bus      : slave side of ps2_keycode_rx_if
//              (ps2_clk/ps2_data in, keycode/key_valid/frame_err out)
// Pipeline: the frame FSM flags a good or bad byte on the stop-bit sample;
// the key tracker consumes that flag on the following edge.
module ps2_keycode_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic               clk,
  input  logic               rst,
  ps2_keycode_rx_if.slave    bus
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic data_s;
  logic fall_pulse;

  ps2_state_e        state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              par_q, par_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic              byte_vld_q, byte_vld_d;
  logic              byte_err_q, byte_err_d;
  logic              tmo_hit_q, tmo_hit_d;
  logic              ext_q, ext_d;
  logic              brk_q, brk_d;
  logic [15:0]       keycode_q, keycode_d;
  logic              key_valid_q, key_valid_d;
  logic              frame_err_q, frame_err_d;
  logic [15:0]       cand;

  ps2_sync_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_sync_filter (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (bus.ps2_clk),
    .ps2_data   (bus.ps2_data),
    .data_s     (data_s),
    .fall_pulse (fall_pulse)
  );

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    tmo_cnt_d   = tmo_cnt_q;
    byte_vld_d  = 1'b0;
    byte_err_d  = 1'b0;
    tmo_hit_d   = 1'b0;
    ext_d       = ext_q;
    brk_d       = brk_q;
    keycode_d   = keycode_q;
    frame_err_d = 1'b0;
    cand        = {(ext_q ? PS2_PREFIX_EXT : 8'h00), shift_q};

    // ---------------- frame receiver ----------------
    case (state_q)
      ST_IDLE: begin
        tmo_cnt_d = '0;
        // A sampled 1 here is line noise / idle level and is ignored.
        if (fall_pulse && !data_s) begin
          state_d   = ST_DATA;
          bit_cnt_d = 3'd0;
        end
      end
      ST_DATA: begin
        if (fall_pulse) begin
          shift_d   = {data_s, shift_q[7:1]};  // LSB arrives first
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end
        end
      end
      ST_PARITY: begin
        if (fall_pulse) begin
          par_d   = data_s;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (fall_pulse) begin
          if (odd_parity_ok(shift_q, par_q) && data_s) begin
            byte_vld_d = 1'b1;
          end else begin
            byte_err_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Inactivity watchdog inside a frame; any sample restarts it.
    if (state_q != ST_IDLE) begin
      if (fall_pulse) begin
        tmo_cnt_d = '0;
      end else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1)) begin
        state_d    = ST_IDLE;
        tmo_cnt_d  = '0;
        shift_d    = 8'h00;
        bit_cnt_d  = 3'd0;
        byte_err_d = 1'b1;
        tmo_hit_d  = 1'b1;
      end else begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
      end
    end

    // ---------------- key tracker ----------------
    // shift_q still holds the accepted byte: the FSM sits in IDLE for at
    // least a whole PS/2 bit time after the stop sample.
    if (byte_vld_q) begin
      if (shift_q == PS2_PREFIX_EXT) begin
        ext_d = 1'b1;
      end else if (shift_q == PS2_PREFIX_BRK) begin
        brk_d = 1'b1;
      end else begin
        if (!brk_q) begin
          keycode_d = cand;
        end else if (keycode_q == cand) begin
          keycode_d = PS2_KEY_NONE;
        end
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end

    if (byte_err_q) begin
      frame_err_d = 1'b1;
      // Only an aborted frame drops the pending prefixes.
      if (tmo_hit_q) begin
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end

    // Typematic repeats rewrite the same value and therefore do not pulse.
    key_valid_d = (keycode_d != keycode_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      par_q       <= 1'b0;
      tmo_cnt_q   <= '0;
      byte_vld_q  <= 1'b0;
      byte_err_q  <= 1'b0;
      tmo_hit_q   <= 1'b0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      keycode_q   <= PS2_KEY_NONE;
      key_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      tmo_cnt_q   <= tmo_cnt_d;
      byte_vld_q  <= byte_vld_d;
      byte_err_q  <= byte_err_d;
      tmo_hit_q   <= tmo_hit_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      keycode_q   <= keycode_d;
      key_valid_q <= key_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.keycode   = keycode_q;
  assign bus.key_valid = key_valid_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Self-checking bench for ps2_keycode_rx. A PS/2 device is emulated at
// 100 system clocks per PS/2 bit (10 kHz PS/2 clock against a 1 MHz clk).
// A key-state model tracks the expected held key and pulse counts; a
// monitor checks every output event against it, and directed checks pin
// literal keycode values after each scenario.
module tb_ps2_keycode_rx;
  import ps2_pkg::*;

  localparam int FILTER_LEN  = 4;
  localparam int TIMEOUT_CYC = 20000;
  localparam int BIT_CYC     = 100;

  logic clk;
  logic rst;

  ps2_keycode_rx_if bus ();

  ps2_keycode_rx #(
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Key-state model.
  logic [15:0] m_key = 16'h0000;
  bit          m_ext = 1'b0;
  bit          m_brk = 1'b0;
  int          m_kv  = 0;
  int          m_fe  = 0;

  // Observed pulse counts.
  int          a_kv  = 0;
  int          a_fe  = 0;
  logic [15:0] prev_kc = 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Apply one accepted byte to the model as a keyboard host would.
  task automatic model_byte(input logic [7:0] b);
    logic [15:0] code;
    logic [15:0] nxt;
    if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      code = m_ext ? {8'hE0, b} : {8'h00, b};
      if (!m_brk)              nxt = code;
      else if (m_key == code)  nxt = 16'h0000;
      else                     nxt = m_key;
      if (nxt != m_key) m_kv++;
      m_key = nxt;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  // Send the first nbits bits of a frame carrying b. glitch_bit >= 0 adds a
  // 2-cycle low glitch in the high phase following that bit.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nbits, input int glitch_bit);
    logic [10:0] fr;
    fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      bus.ps2_data = fr[i];
      wait_cyc(BIT_CYC / 4);
      if (i == 10) begin
        if (!bad_par && !bad_stop) model_byte(b);
        else                       m_fe++;
      end
      bus.ps2_clk = 1'b0;
      wait_cyc(BIT_CYC / 2);
      bus.ps2_clk = 1'b1;
      if (i == glitch_bit) begin
        wait_cyc(10);
        bus.ps2_clk = 1'b0;
        wait_cyc(2);
        bus.ps2_clk = 1'b1;
        wait_cyc(BIT_CYC / 4 - 12);
      end else begin
        wait_cyc(BIT_CYC / 4);
      end
    end
    bus.ps2_data = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 11, -1);
  endtask

  task automatic check_counts(input string name);
    check({name, "_kv_count"}, 32'(a_kv), 32'(m_kv));
    check({name, "_fe_count"}, 32'(a_fe), 32'(m_fe));
  endtask

  // Output monitor: every event cycle is checked against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.key_valid || bus.frame_err || bus.keycode !== prev_kc) begin
          check("kv_fe_exclusive", 32'(bus.key_valid & bus.frame_err), 32'd0);
          check("kv_iff_change", 32'(bus.key_valid), 32'(bus.keycode !== prev_kc));
          if (bus.key_valid) check("kc_on_kv", 32'(bus.keycode), 32'(m_key));
        end
        if (bus.key_valid) a_kv++;
        if (bus.frame_err) a_fe++;
      end
      prev_kc = bus.keycode;
    end
  end

  initial begin
    repeat (200000) @(posedge clk);
    $display("FAIL watchdog: run exceeded cycle budget");
    $fatal(1);
  end

  initial begin
    rst          = 1'b1;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    wait_cyc(5);
    check("rst_keycode",   32'(bus.keycode),   32'h0000);
    check("rst_key_valid", 32'(bus.key_valid), 32'd0);
    check("rst_frame_err", 32'(bus.frame_err), 32'd0);
    rst = 1'b0;
    wait_cyc(20);
    check("post_rst_keycode", 32'(bus.keycode), 32'h0000);

    // Plain make code.
    send(8'h1C);
    check("make_1C", 32'(bus.keycode), 32'h001C);
    check_counts("make_1C");

    // Break, then typematic repeat of a make.
    send(8'hF0); send(8'h1C);
    check("break_1C", 32'(bus.keycode), 32'h0000);
    send(8'h1C); send(8'h1C);
    check("repeat_1C", 32'(bus.keycode), 32'h001C);
    check_counts("repeat_1C");

    // Extended key make/break, and a foreign break while it is held.
    send(8'hE0); send(8'h75);
    check("ext_make", 32'(bus.keycode), 32'hE075);
    send(8'hE0); send(8'hF0); send(8'h75);
    check("ext_break", 32'(bus.keycode), 32'h0000);
    send(8'hE0); send(8'h75);
    send(8'hF0); send(8'h1B);
    check("foreign_break", 32'(bus.keycode), 32'hE075);
    check_counts("ext");

    // Parity error, then stop error.
    send_frame(8'h1C, 1'b1, 1'b0, 11, -1);
    check("bad_parity_kc", 32'(bus.keycode), 32'hE075);
    send_frame(8'h1C, 1'b0, 1'b1, 11, -1);
    check("bad_stop_kc", 32'(bus.keycode), 32'hE075);
    check_counts("frame_errs");

    // Pending E0, then a frame that stalls after 5 bits.
    send(8'hE0);
    send_frame(8'h55, 1'b0, 1'b0, 5, -1);
    m_ext = 1'b0;
    m_brk = 1'b0;
    m_fe++;
    wait_cyc(TIMEOUT_CYC + 200);
    check("tmo_fsm_idle", 32'(dut.state_q), 32'(ST_IDLE));
    check_counts("timeout");
    send(8'h15);
    check("after_tmo", 32'(bus.keycode), 32'h0015);

    // Clock glitch mid-frame must not be taken as a sample.
    send_frame(8'h2A, 1'b0, 1'b0, 11, 4);
    check("glitch_frame", 32'(bus.keycode), 32'h002A);
    check_counts("glitch");

    // Pending break, then reset in the middle of a frame.
    send(8'hF0);
    send_frame(8'h4B, 1'b0, 1'b0, 6, -1);
    rst   = 1'b1;
    m_key = 16'h0000;
    m_ext = 1'b0;
    m_brk = 1'b0;
    wait_cyc(3);
    check("midframe_rst_kc", 32'(bus.keycode), 32'h0000);
    rst = 1'b0;
    wait_cyc(BIT_CYC);
    check("after_rst_kc", 32'(bus.keycode), 32'h0000);
    send(8'h33);
    check("after_rst_frame", 32'(bus.keycode), 32'h0033);
    check_counts("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
